// File: rtl/race_game_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | race_game_ctrl_pkg : state codes and constants for the game sequencer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package race_game_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_RUN       = 3'd2,
      ST_PAUSE     = 3'd3,
      ST_CRASH     = 3'd4,
      ST_OVER      = 3'd5
   } state_t;

   localparam int          SCORE_W   = 14;
   localparam logic [13:0] SCORE_MAX = 14'd9999;

endpackage
`default_nettype wire

// File: rtl/race_game_ctrl_key_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | race_game_ctrl_key_edge : rising-edge detector with sticky flag      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module race_game_ctrl_key_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic key,
   input  logic clr,
   output logic flag
);

   logic prev_q, prev_d;
   logic flag_q, flag_d;

   // An edge landing on the clearing cycle is kept for the next frame.
   always_comb begin
      prev_d = key;
      flag_d = (flag_q & ~clr) | (key & ~prev_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
         flag_q <= flag_d;
      end
   end

   assign flag = flag_q;

endmodule
`default_nettype wire

// File: rtl/race_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | race_game_ctrl : racing game sequencer (FSM, score, lives, level)     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module race_game_ctrl
   import race_game_ctrl_pkg::*;
#(
   parameter int LIVES_INIT   = 3,
   parameter int COUNT_FRAMES = 60,
   parameter int CRASH_FRAMES = 120,
   parameter int SCORE_FRAMES = 6,
   parameter int LEVEL_POINTS = 100,
   parameter int MAX_LEVEL    = 7
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        refresh_tick,
   input  logic        start_key,
   input  logic        pause_key,
   input  logic        car_on,
   input  logic        obstacle_on,
   output logic        game_reset,
   output logic        game_pause,
   output logic [2:0]  state,
   output logic [1:0]  countdown_val,
   output logic [1:0]  lives,
   output logic [13:0] score,
   output logic [2:0]  speed_level,
   output logic        crash_flash
);

   localparam int CNT_MAX = (COUNT_FRAMES > CRASH_FRAMES) ? COUNT_FRAMES : CRASH_FRAMES;
   localparam int CNT_W   = (CNT_MAX > 16) ? $clog2(CNT_MAX) : 4;
   localparam int SC_W    = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;

   localparam logic [CNT_W-1:0]   COUNT_LAST = CNT_W'(COUNT_FRAMES - 1);
   localparam logic [CNT_W-1:0]   CRASH_LAST = CNT_W'(CRASH_FRAMES - 1);
   localparam logic [SC_W-1:0]    SC_LAST    = SC_W'(SCORE_FRAMES - 1);
   localparam logic [SCORE_W-1:0] POINTS     = SCORE_W'(LEVEL_POINTS);
   localparam logic [2:0]         LEVEL_TOP  = 3'(MAX_LEVEL);
   localparam logic [1:0]         LIVES_RST  = 2'(LIVES_INIT);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           cd_q, cd_d;
   logic [1:0]           lives_q, lives_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [SC_W-1:0]      sc_cnt_q, sc_cnt_d;
   logic [2:0]           level_q, level_d;
   logic [SCORE_W-1:0]   thr_q, thr_d;
   logic                 coll_q, coll_d;
   logic                 game_reset_q, game_reset_d;
   logic                 game_pause_q, game_pause_d;
   logic                 crash_flash_q, crash_flash_d;
   logic                 start_flag;
   logic                 pause_flag;

   race_game_ctrl_key_edge u_start_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .key     (start_key),
      .clr     (refresh_tick),
      .flag    (start_flag)
   );

   race_game_ctrl_key_edge u_pause_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .key     (pause_key),
      .clr     (refresh_tick),
      .flag    (pause_flag)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cd_d         = cd_q;
      lives_d      = lives_q;
      score_d      = score_q;
      sc_cnt_d     = sc_cnt_q;
      level_d      = level_q;
      thr_d        = thr_q;
      game_reset_d = 1'b0;
      coll_d       = (coll_q & ~refresh_tick) | (car_on & obstacle_on & (state_q == ST_RUN));

      if (refresh_tick) begin
         case (state_q)
            ST_IDLE, ST_OVER: begin
               if (start_flag) begin
                  state_d      = ST_COUNTDOWN;
                  cnt_d        = '0;
                  cd_d         = 2'd3;
                  lives_d      = LIVES_RST;
                  score_d      = '0;
                  sc_cnt_d     = '0;
                  level_d      = '0;
                  thr_d        = POINTS;
                  game_reset_d = 1'b1;
               end
            end
            ST_COUNTDOWN: begin
               if (cnt_q == COUNT_LAST) begin
                  cnt_d = '0;
                  if (cd_q == 2'd1) begin
                     state_d = ST_RUN;
                     cd_d    = 2'd0;
                  end else begin
                     cd_d = cd_q - 2'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (coll_q) begin
                  state_d = ST_CRASH;
                  cnt_d   = '0;
                  lives_d = lives_q - 2'd1;
               end else if (pause_flag) begin
                  state_d = ST_PAUSE;
               end else begin
                  if (sc_cnt_q == SC_LAST) begin
                     sc_cnt_d = '0;
                     if (score_q != SCORE_MAX) score_d = score_q + 14'd1;
                  end else begin
                     sc_cnt_d = sc_cnt_q + 1'b1;
                  end
                  // Level tracks the next threshold; it climbs at most one step per frame.
                  if ((level_q < LEVEL_TOP) && (score_d >= thr_q)) begin
                     level_d = level_q + 3'd1;
                     thr_d   = thr_q + POINTS;
                  end
               end
            end
            ST_PAUSE: begin
               if (pause_flag) state_d = ST_RUN;
            end
            ST_CRASH: begin
               if (cnt_q == CRASH_LAST) begin
                  cnt_d = '0;
                  if (lives_q == 2'd0) begin
                     state_d = ST_OVER;
                  end else begin
                     state_d      = ST_COUNTDOWN;
                     cd_d         = 2'd3;
                     game_reset_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      game_pause_d  = (state_d != ST_RUN);
      crash_flash_d = (state_d == ST_CRASH) && cnt_d[3];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         cd_q          <= 2'd0;
         lives_q       <= LIVES_RST;
         score_q       <= '0;
         sc_cnt_q      <= '0;
         level_q       <= '0;
         thr_q         <= POINTS;
         coll_q        <= 1'b0;
         game_reset_q  <= 1'b0;
         game_pause_q  <= 1'b1;
         crash_flash_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cd_q          <= cd_d;
         lives_q       <= lives_d;
         score_q       <= score_d;
         sc_cnt_q      <= sc_cnt_d;
         level_q       <= level_d;
         thr_q         <= thr_d;
         coll_q        <= coll_d;
         game_reset_q  <= game_reset_d;
         game_pause_q  <= game_pause_d;
         crash_flash_q <= crash_flash_d;
      end
   end

   assign state         = state_q;
   assign countdown_val = cd_q;
   assign lives         = lives_q;
   assign score         = score_q;
   assign speed_level   = level_q;
   assign game_reset    = game_reset_q;
   assign game_pause    = game_pause_q;
   assign crash_flash   = crash_flash_q;

endmodule
`default_nettype wire
